// File: rtl/add_4_seq_ctrl.sv
// Sequential wide adder controller: feeds an external 4-bit add_4 one nibble per cycle, LSB first,
// recirculating the carry, and returns the assembled sum through a valid/ready result port.
module add_4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_ci,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_ci,
  input  logic [3:0]           add_s,
  input  logic                 add_co,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and valid/data are held until the transfer completes.
  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W+1:0] bit_base;

  assign bit_base = {idx_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = op_ci;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // add_s/add_co are the combinational response to this cycle's registered nibble.
        sum_d[bit_base +: 4] = add_s;
        carry_d              = add_co;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_ci    = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[bit_base +: 4];
      add_b  = b_q[bit_base +: 4];
      add_ci = carry_q;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_add_4_seq_ctrl.sv
// Bench for add_4_seq_ctrl with a behavioural add_4 and an arithmetic reference model.
module tb_add_4_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_ci = 1'b0;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_ci, add_co;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;

  add_4_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_ci(op_ci),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  // Behavioural add_4
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle, 1=busy on nibble m_k, 2=result pending.
  int          m_st = 0;
  int          m_k = 0;
  logic [71:0] m_a = '0, m_b = '0;
  logic        m_ci = 1'b0;

  function automatic logic [71:0] carry_into(input int k);
    logic [71:0] mask;
    mask = (72'd1 << (4 * k)) - 72'd1;
    return ((m_a & mask) + (m_b & mask) + {71'd0, m_ci}) >> (4 * k);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_add", {add_a, add_b, add_ci}, 0);
      m_st = 0;
      m_k  = 0;
    end else begin
      chk("mdl_in_ready", in_ready, (m_st == 0));
      chk("mdl_out_valid", out_valid, (m_st == 2));
      if (m_st == 1) begin
        chk("mdl_add_a", add_a, (m_a >> (4 * m_k)) & 72'hF);
        chk("mdl_add_b", add_b, (m_b >> (4 * m_k)) & 72'hF);
        chk("mdl_add_ci", add_ci, carry_into(m_k) & 72'h1);
      end else begin
        chk("mdl_add_idle", {add_a, add_b, add_ci}, 0);
      end
      if (m_st == 2) chk("mdl_result", {cout, sum}, (m_a + m_b + {71'd0, m_ci}) & ((72'd1 << (W + 1)) - 72'd1));
      case (m_st)
        0: if (in_valid) begin
             m_a = {56'd0, op_a}; m_b = {56'd0, op_b}; m_ci = op_ci; m_k = 0; m_st = 1;
           end
        1: if (m_k == N - 1) m_st = 2; else m_k++;
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  // Directed transaction with literal expectations; call from IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic [W-1:0] es, input logic ec, input logic [N-1:0] ci_seq,
                       input int bp);
    int guard;
    @(posedge clk); #1;
    op_a = a; op_b = b; op_ci = ci; in_valid = 1'b1; out_ready = 1'b0;
    chk("acc_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("run_add_ci", add_ci, ci_seq[k]);
      chk("run_out_valid", out_valid, 0);
    end
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    chk("latency_extra", guard, 0);
    chk("res_sum", sum, es);
    chk("res_cout", cout, ec);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, es);
      chk("bp_cout", cout, ec);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
  endtask

  task automatic wait_valid(input string name);
    int guard;
    guard = 0;
    while (!out_valid && guard < 30) begin
      guard++;
      @(negedge clk);
    end
    chk(name, out_valid, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 4'b1111, 0);
    do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'b0001, 0);
    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000, 5);

    // in_valid held through RUN/DONE with new operands: accepted once back in IDLE.
    @(posedge clk); #1;
    op_a = 16'h1234; op_b = 16'h4321; op_ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h1111; op_b = 16'h1111;
    @(negedge clk);
    wait_valid("hold_valid1");
    chk("hold_sum1", sum, 16'h5555);
    chk("hold_cout1", cout, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("hold_idle", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    chk("hold_accepted", in_ready, 0);
    @(negedge clk);
    wait_valid("hold_valid2");
    chk("hold_sum2", sum, 16'h2222);
    chk("hold_cout2", cout, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_once", out_valid, 0);

    // Reset in the second RUN cycle.
    @(posedge clk); #1;
    op_a = 16'h1234; op_b = 16'h4321; op_ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_add", {add_a, add_b, add_ci}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_result", out_valid, 0);
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish by %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
